// File: rtl/ame_num_denormal_pkg.sv
// ame_pkg: shared FSM state type and saturation constants for ame_num_denormal.
// No ports; imported by the interface users and the top.
package ame_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [63:0] SAT_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] SAT_NEG = 64'h8000_0000_0000_0000;
endpackage

// File: rtl/ame_num_denormal_if.sv
// ame_num_denormal_if: request/result bundle of the sign-magnitude left shifter.
// Requester side: comp_init_i, comp_shift_i, comp_data_i.
// Result side: comp_data_o, comp_busy_o, comp_done_o, comp_ovf_o.
interface ame_num_denormal_if #(parameter int COMP_DATA_BITS = 64);
    logic                              comp_init_i;
    logic [$clog2(COMP_DATA_BITS)-1:0] comp_shift_i;
    logic [COMP_DATA_BITS-1:0]         comp_data_i;
    logic [COMP_DATA_BITS-1:0]         comp_data_o;
    logic                              comp_busy_o;
    logic                              comp_done_o;
    logic                              comp_ovf_o;
    modport master (output comp_init_i, comp_shift_i, comp_data_i,
                    input  comp_data_o, comp_busy_o, comp_done_o, comp_ovf_o);
    modport slave  (input  comp_init_i, comp_shift_i, comp_data_i,
                    output comp_data_o, comp_busy_o, comp_done_o, comp_ovf_o);
endinterface

// File: rtl/ame_num_denormal_sla_stage_64b.sv
// sla_stage_64b: one conditional left shift of a 64-bit magnitude by 2^k.
// i_mag/i_k/i_en in; o_mag shifted value, o_ovf set when any of the top 2^k bits are lost.
module sla_stage_64b (
    input  logic [63:0] i_mag,
    input  logic [2:0]  i_k,
    input  logic        i_en,
    output logic [63:0] o_mag,
    output logic        o_ovf
);
    logic [6:0] w_amt;
    assign w_amt = 7'd1 << i_k;
    assign o_mag = i_en ? i_mag << w_amt : i_mag;
    assign o_ovf = i_en && ((i_mag >> (7'd64 - w_amt)) != '0);
endmodule

// File: rtl/ame_num_denormal.sv
// ame_num_denormal: saturating sign-magnitude left shift, one shift-amount bit per cycle.
// clk_i/rst_i: clock and async active-high reset; bus: slave side of ame_num_denormal_if.
module ame_num_denormal
    import ame_pkg::*;
#(
    parameter int COMP_DATA_BITS = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ame_num_denormal_if.slave    bus
);
    localparam int SW = $clog2(COMP_DATA_BITS);
    state_t                    r_state;
    logic                      r_sign;
    logic [COMP_DATA_BITS-1:0] r_mag;
    logic [SW-1:0]             r_shift;
    logic [2:0]                r_stage;
    logic                      r_sticky;
    logic                      r_fin;
    logic [COMP_DATA_BITS-1:0] r_data;
    logic                      r_ovf;
    logic                      r_done;
    logic [7:0]                w_bits;
    logic [63:0]               w_stage_mag;
    logic                      w_stage_ovf;
    logic                      w_ovf;
    logic [COMP_DATA_BITS-1:0] w_res;

    assign w_bits = {{(8-SW){1'b0}}, r_shift};

    sla_stage_64b u_stage (
        .i_mag (r_mag),
        .i_k   (r_stage),
        .i_en  (r_state == SHIFT && w_bits[r_stage]),
        .o_mag (w_stage_mag),
        .o_ovf (w_stage_ovf)
    );

    // A negative result may reach exactly 2^63; any other set MSB is out of range.
    assign w_ovf = r_sticky | (r_mag[COMP_DATA_BITS-1] & ~(r_sign & r_mag == SAT_NEG));
    assign w_res = w_ovf ? (r_sign ? SAT_NEG : SAT_POS) : (r_sign ? -r_mag : r_mag);

    // r_fin delays publication by one cycle so done lands on the same edge
    // that can accept the next request, giving one op per 8 cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_sign   <= 1'b0;
            r_mag    <= '0;
            r_shift  <= '0;
            r_stage  <= '0;
            r_sticky <= 1'b0;
            r_fin    <= 1'b0;
            r_data   <= '0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= r_fin;
            r_fin  <= r_state == DONE;
            if (r_fin) begin
                r_data <= w_res;
                r_ovf  <= w_ovf;
            end
            case (r_state)
                IDLE: if (bus.comp_init_i) begin
                    r_sign   <= bus.comp_data_i[COMP_DATA_BITS-1];
                    r_mag    <= bus.comp_data_i[COMP_DATA_BITS-1] ? -bus.comp_data_i : bus.comp_data_i;
                    r_shift  <= bus.comp_shift_i;
                    r_stage  <= '0;
                    r_sticky <= 1'b0;
                    r_state  <= SHIFT;
                end
                SHIFT: begin
                    r_mag    <= w_stage_mag;
                    r_sticky <= r_sticky | w_stage_ovf;
                    r_stage  <= r_stage + 3'd1;
                    r_state  <= r_stage == 3'd5 ? DONE : SHIFT;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.comp_data_o = r_data;
    assign bus.comp_ovf_o  = r_ovf;
    assign bus.comp_done_o = r_done;
    assign bus.comp_busy_o = r_state != IDLE;
endmodule

// File: tb/tb_ame_num_denormal.sv
// tb_ame_num_denormal: directed table, reset/back-to-back sequences and random ops vs a reference model.
module tb_ame_num_denormal;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    ame_num_denormal_if #(.COMP_DATA_BITS(64)) bus ();
    ame_num_denormal #(.COMP_DATA_BITS(64)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  shift;
        logic [63:0] exp_data;
        logic        exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact signed result of x * 2^shift, saturated to the 64-bit range.
    task automatic ref_model(input logic [63:0] x, input logic [5:0] sh,
                             output logic [63:0] res, output logic ovf);
        logic        neg;
        logic [127:0] m;
        logic [127:0] lim;
        neg = x[63];
        m   = {64'd0, neg ? (~x + 64'd1) : x} << sh;
        lim = neg ? (128'd1 << 63) : (128'd1 << 63) - 128'd1;
        ovf = m > lim;
        res = ovf ? (neg ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF)
                  : (neg ? -m[63:0] : m[63:0]);
    endtask

    task automatic run_op(input string name, input logic [63:0] d, input logic [5:0] sh,
                          input logic [63:0] exp, input logic exp_ovf);
        int lat;
        bus.comp_data_i  = d;
        bus.comp_shift_i = sh;
        bus.comp_init_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.comp_init_i  = 1'b0;
        bus.comp_data_i  = {$urandom, $urandom};
        bus.comp_shift_i = 6'($urandom);
        check({name, " busy"}, 64'(bus.comp_busy_o), 64'd1);
        lat = 0;
        while (!bus.comp_done_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 64'(lat), 64'd8);
        check({name, " data"}, bus.comp_data_o, exp);
        check({name, " ovf"}, 64'(bus.comp_ovf_o), 64'(exp_ovf));
        @(posedge clk);
        #1;
        check({name, " done pulse"}, 64'(bus.comp_done_o), 64'd0);
    endtask

    vec_t        vecs[8];
    logic [63:0] bd[4];
    logic [5:0]  bs[4];
    logic [63:0] rd;
    logic        ro;

    initial begin
        bus.comp_init_i  = 1'b0;
        bus.comp_data_i  = '0;
        bus.comp_shift_i = '0;
        vecs[0] = '{64'h3, 6'd4, 64'h30, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFD, 6'd2, 64'hFFFF_FFFF_FFFF_FFF4, 1'b0};
        vecs[2] = '{64'h4000_0000_0000_0000, 6'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[3] = '{64'hC000_0000_0000_0000, 6'd1, 64'h8000_0000_0000_0000, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 6'd0, 64'h8000_0000_0000_0000, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 6'd63, 64'h8000_0000_0000_0000, 1'b1};
        vecs[6] = '{64'h0, 6'd37, 64'h0, 1'b0};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 64'h8000_0000_0000_0000, 1'b0};
        repeat (3) @(posedge clk);
        #1;
        check("reset data", bus.comp_data_o, 64'd0);
        check("reset busy", 64'(bus.comp_busy_o), 64'd0);
        check("reset done", 64'(bus.comp_done_o), 64'd0);
        check("reset ovf", 64'(bus.comp_ovf_o), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].data, vecs[i].shift, vecs[i].exp_data, vecs[i].exp_ovf);

        // Reset in the middle of SHIFT, after stage 3 has been reached.
        bus.comp_data_i  = 64'h5;
        bus.comp_shift_i = 6'd3;
        bus.comp_init_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.comp_init_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst data", bus.comp_data_o, 64'd0);
        check("midrst busy", 64'(bus.comp_busy_o), 64'd0);
        check("midrst done", 64'(bus.comp_done_o), 64'd0);
        check("midrst ovf", 64'(bus.comp_ovf_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check("midrst no done", 64'(bus.comp_done_o), 64'd0);
        end
        run_op("after rst", 64'h1, 6'd63, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);

        // init held high: captures every 8 cycles, data changed while busy must be ignored.
        for (int i = 0; i < 4; i++) begin
            bd[i] = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) bd[i] = -bd[i];
            bs[i] = 6'($urandom_range(0, 20));
        end
        bus.comp_data_i  = bd[0];
        bus.comp_shift_i = bs[0];
        bus.comp_init_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i > 0) begin
                ref_model(bd[i-1], bs[i-1], rd, ro);
                check($sformatf("b2b%0d done", i-1), 64'(bus.comp_done_o), 64'd1);
                check($sformatf("b2b%0d data", i-1), bus.comp_data_o, rd);
                check($sformatf("b2b%0d ovf", i-1), 64'(bus.comp_ovf_o), 64'(ro));
            end
            if (i < 3) begin
                bus.comp_data_i  = bd[i+1];
                bus.comp_shift_i = bs[i+1];
                for (int c = 0; c < 7; c++) begin
                    @(posedge clk);
                    #1;
                    check($sformatf("b2b%0d idle done", i), 64'(bus.comp_done_o), 64'd0);
                end
            end
        end
        bus.comp_init_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;

        for (int i = 0; i < 30; i++) begin
            logic [63:0] d;
            logic [5:0]  sh;
            d  = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) d = -d;
            sh = 6'($urandom_range(0, 63));
            ref_model(d, sh, rd, ro);
            run_op($sformatf("rand%0d", i), d, sh, rd, ro);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
